// File: rtl/io_arbiter_if.sv
// io_arbiter_if: requester-side bus of io_arbiter, both requesters packed as {r1, r0}.
interface io_arbiter_if #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 4
);
   logic [1:0]             req;
   logic [1:0]             we;
   logic [2*ADDR_BITS-1:0] addr;
   logic [2*WIDTH-1:0]     wdata;
   logic [1:0]             ack;
   logic [WIDTH-1:0]       rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter: two-requester arbiter in front of a single I/O port block.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority to requester 0.
module io_arbiter #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   io_arbiter_if.slave          bus,
   output logic                 io_en,
   output logic                 io_r_or_w,
   output logic [ADDR_BITS-1:0] io_addr,
   output logic [WIDTH-1:0]     io_wdata,
   input  logic [WIDTH-1:0]     io_rdata,
   output logic                 busy,
   output logic                 last_grant
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;
   state_t                r_state, w_next;
   logic                  w_win, r_win, r_we, r_last;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [WIDTH-1:0]      r_wdata, r_rdata;
   logic [1:0]            r_ack;
   always_ff @(posedge clk)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = (r_state == S_IDLE)   ? (|bus.req ? S_ACCESS : S_IDLE) :
               (r_state == S_ACCESS) ? S_COMPLETE : S_IDLE;
`ifdef IO_ARB_ROUND_ROBIN_EN
      w_win  = (&bus.req) ? ~r_last : ~bus.req[0];
`else
      w_win  = ~bus.req[0];
`endif
   end
   // Request fields are captured only at the grant edge, so later changes cannot disturb the access.
   always_ff @(posedge clk)
      if (rst) begin
         r_win   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_last  <= 1'b1;
         r_ack   <= 2'b00;
         r_rdata <= '0;
      end else begin
         r_ack <= (r_state == S_COMPLETE) ? (2'b01 << r_win) : 2'b00;
         if (r_state == S_COMPLETE) r_rdata <= io_rdata;
         if (r_state == S_IDLE && |bus.req) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_we    <= bus.we[w_win];
            r_addr  <= bus.addr[w_win*ADDR_BITS +: ADDR_BITS];
            r_wdata <= bus.wdata[w_win*WIDTH +: WIDTH];
         end
      end
   assign io_en      = r_state == S_ACCESS;
   assign io_r_or_w  = io_en & r_we;
   assign io_addr    = io_en ? r_addr : '0;
   assign io_wdata   = io_en ? r_wdata : '0;
   assign busy       = r_state != S_IDLE;
   assign last_grant = r_last;
   assign bus.ack    = r_ack;
   assign bus.rdata  = r_rdata;
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: randomized scoreboard bench for io_arbiter with a cycle-count reference model.
module tb_io_arbiter;
   localparam int W = 16;
   localparam int A = 4;
`ifdef IO_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {
      int         cyc;
      int         who;
      logic       we;
      logic [A-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] rdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   io_arbiter_if #(.WIDTH(W), .ADDR_BITS(A)) bus ();
   logic         io_en, io_r_or_w, busy, last_grant;
   logic [A-1:0] io_addr;
   logic [W-1:0] io_wdata, io_rdata;
   logic [W-1:0] blk_mem [16];

   io_arbiter #(.WIDTH(W), .ADDR_BITS(A)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .io_en(io_en), .io_r_or_w(io_r_or_w), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .busy(busy), .last_grant(last_grant)
   );

   function automatic logic [W-1:0] init_val(input int k);
      return W'(k * 4951) ^ 16'hA5A5;
   endfunction

   // I/O port block: registered read of the old contents, write on io_en.
   always @(posedge clk)
      if (rst) begin
         for (int k = 0; k < 16; k++) blk_mem[k] <= init_val(k);
         io_rdata <= '0;
      end else if (io_en) begin
         io_rdata <= blk_mem[io_addr];
         if (io_r_or_w) blk_mem[io_addr] <= io_wdata;
      end

   txn_t         q_io[$], q_ack[$];
   logic [1:0]   ack_log[$];
   logic [W-1:0] ref_mem [16];
   int cyc = 0, g = -10, last_exp = 1;
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one grant per 3 cycles, winner from the request set, data from a plain array.
   initial begin : model
      int   w;
      txn_t t;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            q_io.delete();
            q_ack.delete();
            g = -10;
            last_exp = 1;
            for (int k = 0; k < 16; k++) ref_mem[k] = init_val(k);
         end else if (cyc - g >= 3 && |bus.req) begin
            w = (bus.req == 2'b11) ? (RR ? 1 - last_exp : 0) : (bus.req[0] ? 0 : 1);
            t.cyc   = cyc;
            t.who   = w;
            t.we    = bus.we[w];
            t.addr  = bus.addr[w*A +: A];
            t.wdata = bus.wdata[w*W +: W];
            t.rdata = ref_mem[t.addr];
            if (t.we) ref_mem[t.addr] = t.wdata;
            q_io.push_back(t);
            q_ack.push_back(t);
            g = cyc;
            last_exp = w;
         end
      end
   end

   initial begin : monitor
      txn_t       t;
      logic [1:0] exp_ack;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            chk("io_en", io_en, cyc == g);
            chk("busy", busy, (cyc - g) < 2);
            chk("last_grant", last_grant, last_exp);
            while (q_io.size() > 0 && q_io[0].cyc < cyc) void'(q_io.pop_front());
            if (io_en && q_io.size() > 0) begin
               t = q_io.pop_front();
               chk("io_r_or_w", io_r_or_w, t.we);
               chk("io_addr", io_addr, t.addr);
               chk("io_wdata", io_wdata, t.wdata);
            end else if (!io_en)
               chk("io_idle", {io_r_or_w, io_addr, io_wdata}, 0);
            while (q_ack.size() > 0 && q_ack[0].cyc + 2 < cyc) void'(q_ack.pop_front());
            exp_ack = (q_ack.size() > 0 && q_ack[0].cyc + 2 == cyc) ? 2'(1 << q_ack[0].who) : 2'b00;
            chk("ack", bus.ack, exp_ack);
            if (exp_ack != 2'b00) begin
               t = q_ack.pop_front();
               chk("rdata", bus.rdata, t.rdata);
            end
         end
      end
   end

   task automatic set_fields(input int i);
      bus.we[i]           = 1'($urandom_range(1));
      bus.addr[i*A +: A]  = A'($urandom);
      bus.wdata[i*W +: W] = W'($urandom);
   endtask

   // Requesters hold req until ack, may re-request in the ack cycle, and may change fields while waiting.
   task automatic step(input int p_new, input int p_keep, input int p_scr);
      @(negedge clk);
      if (|bus.ack) ack_log.push_back(bus.ack);
      for (int i = 0; i < 2; i++)
         if (bus.ack[i]) begin
            if (int'($urandom_range(99)) < p_keep) set_fields(i);
            else bus.req[i] = 1'b0;
         end else if (!bus.req[i]) begin
            if (int'($urandom_range(99)) < p_new) begin
               bus.req[i] = 1'b1;
               set_fields(i);
            end
         end else if (int'($urandom_range(99)) < p_scr) set_fields(i);
   endtask

   task automatic do_txn(input int i, input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                         output logic [1:0] ackv, output logic [W-1:0] rd);
      bit got = 0;
      @(negedge clk);
      bus.req             = 2'b00;
      bus.req[i]          = 1'b1;
      bus.we[i]           = w;
      bus.addr[i*A +: A]  = a;
      bus.wdata[i*W +: W] = d;
      ackv = 2'b00;
      rd   = '0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (|bus.ack) begin
            ackv = bus.ack;
            rd   = bus.rdata;
            bus.req = 2'b00;
            got = 1;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL txn_timeout: got no ack expected ack for requester %0d", i);
      end
   endtask

   initial begin
      logic [1:0]   av;
      logic [W-1:0] rd;
      bus.req   = 2'b11;
      bus.we    = 2'b11;
      bus.addr  = '1;
      bus.wdata = '1;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      bus.req = 2'b00;
      chk("rst_ack", bus.ack, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_io_en", io_en, 0);
      chk("rst_last_grant", last_grant, 1);

      do_txn(1, 1'b1, 4'd3, 16'hBEEF, av, rd);
      chk("host_write3_ack", av, 2'b10);
      do_txn(0, 1'b0, 4'd3, 16'h0000, av, rd);
      chk("core_read_ack", av, 2'b01);
      chk("core_read_rdata", rd, 16'hBEEF);
      do_txn(1, 1'b1, 4'd5, 16'h1234, av, rd);
      chk("host_write5_ack", av, 2'b10);

      @(negedge clk);
      ack_log.delete();
      bus.req = 2'b11;
      set_fields(0);
      set_fields(1);
      repeat (10) step(0, 0, 0);
      chk("contention_count", ack_log.size(), 2);
      if (ack_log.size() == 2) begin
         chk("contention_first", ack_log[0], 2'b01);
         chk("contention_second", ack_log[1], 2'b10);
      end

      @(negedge clk);
      ack_log.delete();
      bus.req = 2'b11;
      repeat (12) step(0, 100, 0);
      repeat (8) step(0, 0, 0);
      chk("stream_enough", ack_log.size() >= 4, 1);
      if (ack_log.size() >= 4)
         for (int k = 0; k < 4; k++) chk("stream_grant", ack_log[k], (RR && k % 2) ? 2'b10 : 2'b01);

      @(negedge clk);
      bus.req = 2'b01;
      set_fields(0);
      @(negedge clk);
      chk("pre_rst_io_en", io_en, 1);
      rst     = 1'b1;
      bus.req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_io_en", io_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_last_grant", last_grant, 1);
      for (int k = 0; k < 4; k++) begin
         chk("abort_no_ack", bus.ack, 0);
         @(negedge clk);
      end

      repeat (800) step(30, 40, 30);
      repeat (12) step(0, 0, 0);
      chk("scoreboard_drained", q_ack.size(), 0);
      chk("req_released", bus.req, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the I/O data width.
REQ-002 The module SHALL have parameter ADDR_BITS, default 4, giving the I/O port address width.
REQ-003 Port clk, input, 1 -- the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 -- synchronous, active-high reset.
REQ-005 Port req, input, 2 -- per-requester access request; bit 0 is the core and bit 1 is the host/loader.
REQ-006 Port we, input, 2 -- per-requester direction; 1 = write, 0 = read.
REQ-007 Port addr, input, 2*ADDR_BITS -- addresses packed as {addr1, addr0}.
REQ-008 Port wdata, input, 2*WIDTH -- write data packed as {wdata1, wdata0}.
REQ-009 Port ack, output, 2 -- per-requester one-cycle completion pulse.
REQ-010 Port rdata, output, WIDTH -- read data, valid while any ack bit is high.
REQ-011 Port io_en, output, 1 -- enable to the I/O port block.
REQ-012 Port io_r_or_w, output, 1 -- direction to the I/O port block; 1 = write.
REQ-013 Port io_addr, output, ADDR_BITS -- port address to the I/O port block.
REQ-014 Port io_wdata, output, WIDTH -- write data to the I/O port block.
REQ-015 Port io_rdata, input, WIDTH -- registered read data from the I/O port block, valid one cycle after io_en.
REQ-016 Port busy, output, 1 -- high whenever the FSM is not in IDLE.
REQ-017 Port last_grant, output, 1 -- index of the most recently granted requester.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, COMPLETE.
REQ-019 IDLE: if any req bit is high at the clock edge, the FSM SHALL select a winner, latch its we/addr/wdata, update last_grant to the winner, and go to ACCESS; with no request it SHALL remain in IDLE.
REQ-020 ACCESS: io_en=1 for exactly one cycle, with io_r_or_w/io_addr/io_wdata driven from the latched values; next state SHALL be COMPLETE.
REQ-021 COMPLETE: rdata SHALL be registered from io_rdata (writes included), ack[winner] SHALL pulse for one cycle starting at the next edge, and the next state SHALL be IDLE.
REQ-022 Latency: req sampled at edge N -> io_en high during cycle N..N+1 -> ack high during cycle N+2..N+3.
REQ-023 Minimum spacing between grants: 3 cycles; at most one transaction is outstanding.
REQ-024 Requesters SHALL hold req until ack and deassert it in the ack cycle; req still high at the edge ending the ack cycle SHALL be treated as a new request.
REQ-025 Changes to req/we/addr/wdata while busy=1 SHALL NOT affect the transaction in flight.
REQ-026 Outside ACCESS, io_en, io_r_or_w, io_addr and io_wdata SHALL all be 0.
REQ-027 ack bits SHALL be one-hot or zero and never high outside the cycle after COMPLETE.
REQ-028 Simultaneous requests SHALL be resolved per REQ-033.
REQ-029 A requester withdrawing req while not granted SHALL be legal; no ack is issued to it.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL go to IDLE and a transaction in flight SHALL be abandoned without an ack.
REQ-031 After reset, ack, rdata, busy and all io_* outputs SHALL be 0, and last_grant SHALL be 1.
REQ-032 Requests present in the reset cycle SHALL be ignored; they are re-sampled at the first edge with rst=0.

Configuration
REQ-033 Macro IO_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL be granted to the requester not equal to last_grant; when undefined, priority is fixed with req[0] always winning, and last_grant is still updated.

Verification
REQ-034 Core read: req=01, we=00, addr0=3, io_rdata=16'hBEEF -> io_en pulses once with io_addr=3 and io_r_or_w=0; two cycles later ack=01 and rdata=16'hBEEF.
REQ-035 Host write: req=10, we=10, addr1=5, wdata1=16'h1234 -> one io_en cycle with io_r_or_w=1, io_addr=5, io_wdata=16'h1234; then ack=10.
REQ-036 Contention: req=11 held, each requester dropping its bit on its own ack -> with the macro, acks go 01 then 10; without it, 01 then 10 only after req[0] drops.
REQ-037 Continuous req=11 for 12 cycles, with req re-asserted after each ack -> with the macro, grants alternate 0,1,0,1 at 3-cycle spacing; without it, all grants go to 0.
REQ-038 rst asserted during ACCESS -> next cycle io_en=0 and busy=0, no ack is issued, and last_grant=1.
